// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, FSM states and
// the legal multiply-latency range.
package mdu_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MADD = 3'd3;
    localparam logic [2:0] OP_MSUB = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5;
    localparam logic [2:0] OP_MTLO = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

    // The latency counter is 4 bits wide, which bounds MUL_LAT.
    localparam int MUL_LAT_MIN = 1;
    localparam int MUL_LAT_MAX = 15;

    function automatic bit mul_lat_legal(input int lat);
        return (lat >= MUL_LAT_MIN) && (lat <= MUL_LAT_MAX);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles per divide.
// done is high during the final iteration; quotient/remainder are valid the cycle after.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             active_q, active_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // The dividend shifts out of quo_q into the partial remainder while quotient bits shift in.
    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b0, dvsr_q};
        done     = active_q && (cnt_q == LAST);

        if (start) begin
            rem_d    = '0;
            quo_d    = dividend;
            dvsr_d   = divisor;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (!diff[WIDTH+1]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (done) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit owning HI/LO: multi-cycle multiply, iterative divide, MTHI/MTLO.
// MADD/MSUB are present only when MDU_MADD_EN is defined.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       md_op,
    input  logic             is_signed,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    if (!mul_lat_legal(MUL_LAT)) begin : g_bad_mul_lat
        $error("mdu_iter: MUL_LAT must be within 1..15");
    end

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               sgn_q, sgn_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic               op_ok, accept;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_result;
    logic               a_in_neg, b_in_neg, a_neg, b_neg;
    logic [WIDTH-1:0]   a_in_mag, b_in_mag;
    logic               div_start, div_done;
    logic [WIDTH-1:0]   quotient, remainder;

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a_in_mag),
        .divisor   (b_in_mag),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Operand preparation: sign-extended product and divider magnitudes, all from the live inputs.
    always_comb begin
        ext_a    = {{WIDTH{is_signed & op_a[WIDTH-1]}}, op_a};
        ext_b    = {{WIDTH{is_signed & op_b[WIDTH-1]}}, op_b};
        product  = ext_a * ext_b;
        a_in_neg = is_signed & op_a[WIDTH-1];
        b_in_neg = is_signed & op_b[WIDTH-1];
        a_in_mag = a_in_neg ? -op_a : op_a;
        b_in_mag = b_in_neg ? -op_b : op_b;
        a_neg    = sgn_q & a_q[WIDTH-1];
        b_neg    = sgn_q & b_q[WIDTH-1];

        case (md_op)
            OP_MULT, OP_DIV, OP_MTHI, OP_MTLO: op_ok = 1'b1;
            OP_MADD, OP_MSUB:                  op_ok = MADD_EN;
            default:                           op_ok = 1'b0;
        endcase
        accept = (state_q == ST_IDLE) && op_ok;

        mul_result = prod_q;
        if (MADD_EN && (op_q == OP_MADD)) begin
            mul_result = {hi_q, lo_q} + prod_q;
        end else if (MADD_EN && (op_q == OP_MSUB)) begin
            mul_result = {hi_q, lo_q} - prod_q;
        end
    end

    // FSM: HI/LO are only written on acceptance (MTHI/MTLO) or when leaving MUL/FIX.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        prod_d    = prod_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        div_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = md_op;
                    a_d   = op_a;
                    b_d   = op_b;
                    sgn_d = is_signed;
                    dbz_d = 1'b0;
                    cnt_d = '0;
                    case (md_op)
                        OP_MTHI: hi_d = op_a;
                        OP_MTLO: lo_d = op_a;
                        OP_DIV: begin
                            state_d   = ST_DIV;
                            div_start = 1'b1;
                        end
                        default: begin
                            prod_d  = product;
                            state_d = ST_MUL;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    state_d      = ST_IDLE;
                    {hi_d, lo_d} = mul_result;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (b_q == '0) begin
                    hi_d  = a_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d = a_neg ? -remainder : remainder;
                    lo_d = (a_neg ^ b_neg) ? -quotient : quotient;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32, MUL_LAT=5); MADD/MSUB expectations follow MDU_MADD_EN.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op_a, op_b;
    logic [2:0]  md_op;
    logic        is_signed;
    logic        busy;
    logic [31:0] hi, lo;
    logic        dbz;

    int compared   = 0;
    int mismatched = 0;
    int cycles;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_a      (op_a),
        .op_b      (op_b),
        .md_op     (md_op),
        .is_signed (is_signed),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .dbz       (dbz)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one op for exactly one rising edge; returns in the first cycle after acceptance.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        md_op     = op;
        op_a      = a;
        op_b      = b;
        is_signed = s;
        @(negedge clk);
        md_op = OP_NOP;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation stopped by watchdog");
    end

    initial begin
        reset     = 1'b1;
        md_op     = OP_NOP;
        op_a      = '0;
        op_b      = '0;
        is_signed = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        checkOutput("reset_dbz", dbz, 0);
        reset = 1'b0;

        applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
        checkOutput("mults_busy_rise", busy, 1);
        waitIdle(cycles);
        checkOutput("mults_cycles", cycles, 5);
        checkOutput("mults_hi", hi, 32'hFFFFFFFF);
        checkOutput("mults_lo", lo, 32'hFFFFFFFA);

        applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
        waitIdle(cycles);
        checkOutput("multu_hi", hi, 32'h00000002);
        checkOutput("multu_lo", lo, 32'hFFFFFFFA);

        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        checkOutput("divs_busy_rise", busy, 1);
        waitIdle(cycles);
        checkOutput("divs_cycles", cycles, 33);
        checkOutput("divs_lo", lo, 32'hFFFFFFFD);
        checkOutput("divs_hi", hi, 32'hFFFFFFFF);
        checkOutput("divs_dbz", dbz, 0);

        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        waitIdle(cycles);
        checkOutput("divmin_lo", lo, 32'h80000000);
        checkOutput("divmin_hi", hi, 32'h00000000);

        applyStimulus(OP_DIV, 32'hFFFFFFFF, 32'd16, 1'b0);
        waitIdle(cycles);
        checkOutput("divu_lo", lo, 32'h0FFFFFFF);
        checkOutput("divu_hi", hi, 32'h0000000F);

        applyStimulus(OP_DIV, 32'd100, 32'd0, 1'b0);
        waitIdle(cycles);
        checkOutput("dbz_cycles", cycles, 33);
        checkOutput("dbz_hi", hi, 32'd100);
        checkOutput("dbz_lo", lo, 32'hFFFFFFFF);
        checkOutput("dbz_flag", dbz, 1);

        applyStimulus(OP_MTLO, 32'd5, 32'd0, 1'b0);
        checkOutput("mtlo_busy", busy, 0);
        checkOutput("mtlo_lo", lo, 32'd5);
        checkOutput("mtlo_hi", hi, 32'd100);
        checkOutput("mtlo_dbz", dbz, 0);

        applyStimulus(OP_MTHI, 32'd0, 32'd0, 1'b0);
        applyStimulus(OP_MTLO, 32'd1, 32'd0, 1'b0);
        checkOutput("mt_hi", hi, 32'd0);
        checkOutput("mt_lo", lo, 32'd1);
        applyStimulus(OP_MADD, 32'd2, 32'd3, 1'b1);
`ifdef MDU_MADD_EN
        checkOutput("madd_busy_rise", busy, 1);
        waitIdle(cycles);
        checkOutput("madd_cycles", cycles, 5);
        checkOutput("madd_lo", lo, 32'd7);
        checkOutput("madd_hi", hi, 32'd0);
        applyStimulus(OP_MSUB, 32'd1, 32'd8, 1'b1);
        waitIdle(cycles);
        checkOutput("msub_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
`else
        checkOutput("madd_off_busy", busy, 0);
        checkOutput("madd_off_lo", lo, 32'd1);
        checkOutput("madd_off_hi", hi, 32'd0);
        applyStimulus(OP_MSUB, 32'd1, 32'd8, 1'b1);
        checkOutput("msub_off_busy", busy, 0);
        checkOutput("msub_off_lo", lo, 32'd1);
`endif

        // A MULT presented in cycle 3 of a DIV must be dropped without disturbing it.
        applyStimulus(OP_MTHI, 32'h11, 32'd0, 1'b0);
        applyStimulus(OP_MTLO, 32'h22, 32'd0, 1'b0);
        applyStimulus(OP_DIV, 32'd1000, 32'hFFFFFFFD, 1'b1);
        @(negedge clk);
        @(negedge clk);
        md_op     = OP_MULT;
        op_a      = 32'd5;
        op_b      = 32'd5;
        is_signed = 1'b0;
        @(negedge clk);
        md_op = OP_NOP;
        checkOutput("ignore_mid_hi", hi, 32'h11);
        checkOutput("ignore_mid_lo", lo, 32'h22);
        waitIdle(cycles);
        checkOutput("ignore_cycles", cycles, 30);
        checkOutput("ignore_lo", lo, 32'hFFFFFEB3);
        checkOutput("ignore_hi", hi, 32'h00000001);

        // Back-to-back issue in the first idle cycle.
        applyStimulus(OP_MULT, 32'd7, 32'd6, 1'b0);
        waitIdle(cycles);
        checkOutput("b2b_first_lo", lo, 32'd42);
        md_op     = OP_MULT;
        op_a      = 32'd3;
        op_b      = 32'd4;
        is_signed = 1'b0;
        @(negedge clk);
        md_op = OP_NOP;
        checkOutput("b2b_busy", busy, 1);
        checkOutput("b2b_mid_lo", lo, 32'd42);
        waitIdle(cycles);
        checkOutput("b2b_cycles", cycles, 5);
        checkOutput("b2b_lo", lo, 32'd12);

        // Reset in cycle 10 of a DIV aborts it with no late writeback.
        applyStimulus(OP_DIV, 32'd50, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rstdiv_busy", busy, 0);
        checkOutput("rstdiv_hi", hi, 0);
        checkOutput("rstdiv_lo", lo, 0);
        repeat (40) @(negedge clk);
        checkOutput("rstdiv_late_busy", busy, 0);
        checkOutput("rstdiv_late_lo", lo, 0);
        checkOutput("rstdiv_late_hi", hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core, owning the HI/LO register pair. It supports signed and unsigned multiply, iterative restoring divide and direct HI/LO writes. Optional multiply-accumulate ops are compiled in by macro. It reports `busy` so the hazard unit can stall MFHI/MFLO and any further MD ops.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `MUL_LAT`, 5: multiply busy cycles, legal range 1..15.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `op_a` in WIDTH: rs operand, the dividend, and the data for MTHI/MTLO.
- `op_b` in WIDTH: rt operand, the divisor.
- `md_op` in 3: 0 NOP, 1 MULT, 2 DIV, 3 MADD, 4 MSUB, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- `is_signed` in 1: selects signed interpretation for MULT, DIV, MADD and MSUB.
- `busy` out 1: an operation is in flight.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `dbz` out 1: the last completed DIV had a zero divisor. It is sticky until the next accepted op.

## Operation
- Reset values: `busy`=0, `hi`=0, `lo`=0, `dbz`=0, FSM=IDLE. A reset in any state aborts the operation in flight and discards its result.
- FSM states are IDLE, MUL, DIV and FIX.
- An op is accepted only in IDLE with `md_op` nonzero. The operands and `is_signed` are latched at acceptance.
- A nonzero `md_op` while busy is ignored. The hazard unit must stall; the bench checks that HI, LO and timing are unaffected.
- MTHI and MTLO write `hi` or `lo` at the accepting edge and do not raise `busy`.
- MULT and MADD/MSUB compute a 2·WIDTH product at acceptance. The FSM goes IDLE→MUL, and a counter runs to `MUL_LAT`.
  - MULT writes {hi,lo}=product.
  - MADD writes {hi,lo}+=product; MSUB writes {hi,lo}-=product. Both wrap modulo 2^(2·WIDTH).
- DIV goes IDLE→DIV. It runs WIDTH restoring iterations on magnitudes, then DIV→FIX applies signs.
  - LO receives the quotient, truncated toward zero.
  - HI receives the remainder, with the sign of the dividend.
  - Signed MIN/−1 gives lo=MIN and hi=0, with no trap.
- Divide by zero gives hi=op_a, lo=all ones and `dbz`=1. The FSM still takes the full DIV latency.
- Any accepted op other than DIV clears `dbz`.

## Timing
- Acceptance happens on edge E. `busy` is high from the cycle after E.
- MULT/MADD/MSUB: `busy` stays high for exactly `MUL_LAT` cycles. The new hi/lo are visible in the first cycle with `busy` low.
- DIV: `busy` stays high for WIDTH+1 cycles (WIDTH iterations plus FIX). The new hi/lo and `dbz` are visible in the first cycle with `busy` low.
- A new op may be accepted in that same first low cycle, giving back-to-back issue.
- hi/lo never change mid-operation. Intermediate values live in internal registers.

## Configuration
- `MDU_MADD_EN` defined: MADD and MSUB are implemented as described above.
- `MDU_MADD_EN` undefined: codes 3 and 4 are treated as NOP. They are not accepted, `busy` stays low, hi/lo are unchanged and `dbz` is unaffected. The accumulate adder is absent.

## Structure
- The package `mdu_pkg` holds:
  - the `md_op` encodings as localparams/enum;
  - the FSM state enum;
  - the `MUL_LAT` legality check constant.
- The sub-module `mdu_div_core` holds the WIDTH-cycle restoring divider. Its interface is start/done, unsigned magnitudes, and quotient and remainder outputs.
- The top level handles sign conversion, the FSM, the latency counter, the multiplier and HI/LO.

## Test plan
All scenarios use WIDTH=32 and MUL_LAT=5.
- Signed MULT 0xFFFFFFFE×3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA; `busy` high for exactly 5 cycles.
- Unsigned MULT 0xFFFFFFFE×3 → hi=0x00000002, lo=0xFFFFFFFA.
- Signed DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; `busy` high for 33 cycles. Signed 0x80000000/−1 → lo=0x80000000, hi=0.
- DIV 100/0 → hi=100, lo=0xFFFFFFFF, `dbz`=1. A following MTLO 5 → `dbz`=0, lo=5.
- MTHI 0, MTLO 1, then MADD 2×3 → lo=7. Then MSUB 1×8 → {hi,lo}=0xFFFFFFFF_FFFFFFFF. Without `MDU_MADD_EN`: lo stays 1 and `busy` never rises.
- Busy handling and reset:
  - MULT issued on cycle 3 of a DIV → ignored; the DIV result is correct.
  - `reset` on cycle 10 of a DIV → next cycle `busy`=0, hi=lo=0; no late writeback.
